// File: rtl/iter_term_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : iter_term_ctrl
// Purpose  : Iteration-termination controller for the LDPC decoder system
//            FSM. Counts completed decoding iterations by edge-detecting the
//            P2P_V_OUT state of sys_control_unit. Ends a frame on the
//            iteration limit or on an all-zero syndrome (early termination).
//            Reports per-frame status and running frame/failure statistics.
// Ports    :
//   read_clk        in   1       system clock (shared with sys_control_unit)
//   rstn            in   1       asynchronous active-low reset
//   fsm_state       in   4       current sys_control_unit state code
//   de_frame_start  in   1       frame-start strobe
//   syndrome_valid  in   1       syndrome check result valid this cycle
//   syndrome_zero   in   1       all parity checks satisfied
//   early_term_en   in   1       enables syndrome-based early termination
//   termination     out  1       high = stop current frame (TERM state)
//   iter_cnt        out  ITER_W  iterations completed in current frame
//   decode_done     out  1       one-cycle pulse on frame termination
//   decode_success  out  1       status of last terminated frame
//   frame_cnt       out  STAT_W  frames terminated since reset
//   fail_cnt        out  STAT_W  unsuccessful frames since reset
//   busy            out  1       frame in progress (RUN or TERM)
// Revision : 1.0 - initial release
// ============================================================================
module iter_term_ctrl #(
  parameter int         MAX_ITER     = 10,
  parameter int         ITER_W       = 4,
  parameter int         STAT_W       = 16,
  parameter logic [3:0] ST_P2P_V_OUT = 4'b1010
) (
  input  logic              read_clk,
  input  logic              rstn,
  input  logic [3:0]        fsm_state,
  input  logic              de_frame_start,
  input  logic              syndrome_valid,
  input  logic              syndrome_zero,
  input  logic              early_term_en,
  output logic              termination,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              decode_done,
  output logic              decode_success,
  output logic [STAT_W-1:0] frame_cnt,
  output logic [STAT_W-1:0] fail_cnt,
  output logic              busy
);

  // Limit held one bit wider than the counter so the increment compare
  // cannot overflow even when MAX_ITER equals the counter's maximum code.
  localparam logic [ITER_W:0] MAX_ITER_EXT = (ITER_W+1)'(MAX_ITER);
  localparam logic [ITER_W:0] ONE_EXT      = (ITER_W+1)'(1);
  localparam logic [STAT_W-1:0] STAT_ONE   = STAT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TERM = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [3:0]          prev_state;

  logic                it_done;
  logic                syn_ok;
  logic                early_exit;
  logic                limit_exit;
  logic [ITER_W:0]     iter_inc;

  logic [ITER_W-1:0]   iter_cnt_nxt;
  logic                termination_nxt;
  logic                decode_done_nxt;
  logic                decode_success_nxt;
  logic [STAT_W-1:0]   frame_cnt_nxt;
  logic [STAT_W-1:0]   fail_cnt_nxt;

  // --------------------------------------------------------------------------
  // Iteration tick: rising edge into P2P_V_OUT, so a multi-cycle visit to
  // that state still counts as a single completed iteration.
  // --------------------------------------------------------------------------
  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      prev_state <= 4'b0000;
    end else begin
      prev_state <= fsm_state;
    end
  end

  assign it_done    = (fsm_state == ST_P2P_V_OUT) && (prev_state != ST_P2P_V_OUT);
  assign syn_ok     = syndrome_valid && syndrome_zero;
  assign iter_inc   = {1'b0, iter_cnt} + ONE_EXT;
  assign early_exit = early_term_en && syn_ok;
  assign limit_exit = it_done && (iter_inc == MAX_ITER_EXT);

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      iter_cnt       <= '0;
      termination    <= 1'b0;
      decode_done    <= 1'b0;
      decode_success <= 1'b0;
      frame_cnt      <= '0;
      fail_cnt       <= '0;
    end else begin
      state          <= state_nxt;
      iter_cnt       <= iter_cnt_nxt;
      termination    <= termination_nxt;
      decode_done    <= decode_done_nxt;
      decode_success <= decode_success_nxt;
      frame_cnt      <= frame_cnt_nxt;
      fail_cnt       <= fail_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt          = state;
    iter_cnt_nxt       = iter_cnt;
    decode_done_nxt    = 1'b0;
    decode_success_nxt = decode_success;
    frame_cnt_nxt      = frame_cnt;
    fail_cnt_nxt       = fail_cnt;

    unique case (state)
      IDLE: begin
        if (de_frame_start) begin
          state_nxt    = RUN;
          iter_cnt_nxt = '0;
        end
      end

      RUN: begin
        // Count the iteration even on an exit cycle; saturate at the limit.
        if (it_done && (iter_inc <= MAX_ITER_EXT)) begin
          iter_cnt_nxt = iter_inc[ITER_W-1:0];
        end

        if (early_exit || limit_exit) begin
          // Success wins when both exits coincide; one TERM entry either way.
          state_nxt          = TERM;
          decode_done_nxt    = 1'b1;
          decode_success_nxt = early_exit;
          frame_cnt_nxt      = frame_cnt + STAT_ONE;
          if (!early_exit) begin
            fail_cnt_nxt = fail_cnt + STAT_ONE;
          end
        end else if (de_frame_start) begin
          // Mid-frame restart discards progress without closing the frame.
          iter_cnt_nxt = '0;
        end
      end

      TERM: begin
        if (de_frame_start) begin
          state_nxt    = RUN;
          iter_cnt_nxt = '0;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    termination_nxt = (state_nxt == TERM);
  end

  assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_iter_term_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_iter_term_ctrl
// Purpose  : Self-checking directed testbench for iter_term_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iter_term_ctrl;

  localparam logic [3:0] P2P   = 4'b1010;
  localparam logic [3:0] OTHER = 4'b0011;

  logic        read_clk;
  logic        rstn;
  logic [3:0]  fsm_state;
  logic        de_frame_start;
  logic        syndrome_valid;
  logic        syndrome_zero;
  logic        early_term_en;
  logic        termination;
  logic [3:0]  iter_cnt;
  logic        decode_done;
  logic        decode_success;
  logic [15:0] frame_cnt;
  logic [15:0] fail_cnt;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  iter_term_ctrl #(
    .MAX_ITER     (10),
    .ITER_W       (4),
    .STAT_W       (16),
    .ST_P2P_V_OUT (P2P)
  ) dut (
    .read_clk       (read_clk),
    .rstn           (rstn),
    .fsm_state      (fsm_state),
    .de_frame_start (de_frame_start),
    .syndrome_valid (syndrome_valid),
    .syndrome_zero  (syndrome_zero),
    .early_term_en  (early_term_en),
    .termination    (termination),
    .iter_cnt       (iter_cnt),
    .decode_done    (decode_done),
    .decode_success (decode_success),
    .frame_cnt      (frame_cnt),
    .fail_cnt       (fail_cnt),
    .busy           (busy)
  );

  initial read_clk = 1'b0;
  always #5 read_clk = ~read_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge read_clk);
    #1;
  endtask

  // One single-cycle P2P_V_OUT visit followed by one cycle elsewhere.
  task automatic visits(input int n);
    for (int i = 0; i < n; i++) begin
      fsm_state = P2P;
      step();
      fsm_state = OTHER;
      step();
    end
  endtask

  task automatic start_frame();
    de_frame_start = 1'b1;
    step();
    de_frame_start = 1'b0;
  endtask

  initial begin
    rstn           = 1'b0;
    fsm_state      = OTHER;
    de_frame_start = 1'b0;
    syndrome_valid = 1'b0;
    syndrome_zero  = 1'b0;
    early_term_en  = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_term",  termination,    0);
    chk("rst_busy",  busy,           0);
    chk("rst_iter",  iter_cnt,       0);
    chk("rst_done",  decode_done,    0);
    chk("rst_succ",  decode_success, 0);
    chk("rst_frame", frame_cnt,      0);
    chk("rst_fail",  fail_cnt,       0);
    rstn = 1'b1;
    step();

    // IDLE ignores ticks and syndrome
    syndrome_valid = 1'b1; syndrome_zero = 1'b1; early_term_en = 1'b1;
    visits(2);
    syndrome_valid = 1'b0; syndrome_zero = 1'b0; early_term_en = 1'b0;
    chk("idle_iter", iter_cnt, 0);
    chk("idle_busy", busy, 0);

    // ---- Limit exit ----
    start_frame();
    chk("l_busy", busy, 1);
    chk("l_iter0", iter_cnt, 0);
    visits(9);
    chk("l_iter9", iter_cnt, 9);
    chk("l_term9", termination, 0);
    fsm_state = P2P;
    step();
    fsm_state = OTHER;
    chk("l_term", termination, 1);
    chk("l_done", decode_done, 1);
    chk("l_succ", decode_success, 0);
    chk("l_iter", iter_cnt, 10);
    chk("l_frame", frame_cnt, 1);
    chk("l_fail", fail_cnt, 1);
    step();
    chk("l_done_pulse", decode_done, 0);
    chk("l_term_hold", termination, 1);
    visits(1);
    chk("l_iter_frozen", iter_cnt, 10);

    // ---- Handover TERM -> RUN, early exit ----
    start_frame();
    chk("h_term", termination, 0);
    chk("h_iter", iter_cnt, 0);
    early_term_en = 1'b1;
    visits(3);
    syndrome_zero = 1'b1;          // not qualified: must not exit
    step();
    chk("e_unqual", termination, 0);
    syndrome_valid = 1'b1;
    step();
    syndrome_valid = 1'b0; syndrome_zero = 1'b0;
    chk("e_term", termination, 1);
    chk("e_done", decode_done, 1);
    chk("e_succ", decode_success, 1);
    chk("e_iter", iter_cnt, 3);
    chk("e_frame", frame_cnt, 2);
    chk("e_fail", fail_cnt, 1);

    // ---- Early exit disabled ----
    early_term_en = 1'b0;
    start_frame();
    visits(3);
    syndrome_valid = 1'b1; syndrome_zero = 1'b1;
    step();
    syndrome_valid = 1'b0; syndrome_zero = 1'b0;
    chk("d_term", termination, 0);
    visits(7);
    chk("d_iter", iter_cnt, 10);
    chk("d_succ", decode_success, 0);
    chk("d_frame", frame_cnt, 3);
    chk("d_fail", fail_cnt, 2);

    // ---- Same-cycle exits ----
    early_term_en = 1'b1;
    start_frame();
    visits(9);
    fsm_state = P2P; syndrome_valid = 1'b1; syndrome_zero = 1'b1;
    step();
    fsm_state = OTHER; syndrome_valid = 1'b0; syndrome_zero = 1'b0;
    chk("s_done", decode_done, 1);
    chk("s_succ", decode_success, 1);
    chk("s_iter", iter_cnt, 10);
    chk("s_frame", frame_cnt, 4);
    chk("s_fail", fail_cnt, 2);
    step();
    chk("s_single", decode_done, 0);
    chk("s_frame2", frame_cnt, 4);
    early_term_en = 1'b0;

    // ---- Edge detect: 3-cycle P2P visit counts once ----
    start_frame();
    fsm_state = P2P;
    step(); step(); step();
    fsm_state = OTHER;
    step();
    chk("ed_iter", iter_cnt, 1);
    visits(9);
    chk("ed_term", termination, 1);
    chk("ed_frame", frame_cnt, 5);
    chk("ed_fail", fail_cnt, 3);

    // ---- Mid-frame restart ----
    start_frame();
    visits(5);
    chk("r_iter5", iter_cnt, 5);
    de_frame_start = 1'b1;
    step();
    de_frame_start = 1'b0;
    chk("r_iter0", iter_cnt, 0);
    chk("r_done", decode_done, 0);
    chk("r_busy", busy, 1);
    chk("r_frame", frame_cnt, 5);
    visits(10);
    chk("r_term", termination, 1);
    chk("r_frame2", frame_cnt, 6);
    chk("r_fail", fail_cnt, 4);

    // ---- Async reset in TERM, between edges ----
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_term", termination, 0);
    chk("ar_busy", busy, 0);
    chk("ar_iter", iter_cnt, 0);
    chk("ar_frame", frame_cnt, 0);
    chk("ar_fail", fail_cnt, 0);
    step();
    rstn = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iter_term_ctrl.md
Name: iter_term_ctrl

Overview:
Iteration-termination controller sitting directly upstream of sys_control_unit; it produces the `termination` input that the system FSM currently receives from a bench register. It counts completed decoding iterations from the system FSM state stream. It ends a frame either on the max-iteration limit or on an all-zero syndrome (early termination), and reports per-frame status and running frame/failure statistics.

Parameters:
MAX_ITER, 10, maximum decoding iterations per frame (legal range 1..2**ITER_W-1)
ITER_W, 4, width of iteration counter
STAT_W, 16, width of frame/failure statistics counters
ST_P2P_V_OUT, 4'b1010, system-FSM state code marking end of one iteration

Ports:
read_clk  in  1  system clock (same clock as sys_control_unit)
rstn  in  1  asynchronous active-low reset
fsm_state  in  4  current state of sys_control_unit
de_frame_start  in  1  frame-start strobe from sys_control_unit
syndrome_valid  in  1  syndrome check result valid this cycle
syndrome_zero  in  1  all parity checks satisfied (qualified by syndrome_valid)
early_term_en  in  1  enables syndrome-based early termination
termination  out  1  to sys_control_unit; high = stop current frame
iter_cnt  out  ITER_W  iterations completed in current frame
decode_done  out  1  one-cycle pulse when a frame terminates
decode_success  out  1  status of last terminated frame (1 = syndrome zero)
frame_cnt  out  STAT_W  frames terminated since reset
fail_cnt  out  STAT_W  frames terminated without success since reset
busy  out  1  high while a frame is being decoded (RUN or TERM)

Behaviour:
- Reset (rstn=0, async): state IDLE; all outputs 0; edge-detect register for fsm_state cleared to 4'b0000.
- Iteration tick `it_done` = (fsm_state==ST_P2P_V_OUT) && (prev_state!=ST_P2P_V_OUT). prev_state is fsm_state registered on read_clk. At most one tick is generated per P2P_V_OUT visit.
- Syndrome pass `syn_ok` = syndrome_valid && syndrome_zero.
- States: IDLE, RUN, TERM.
- IDLE:
  - de_frame_start=1 -> RUN, iter_cnt<=0.
  - it_done and syndrome inputs are ignored.
- RUN:
  - it_done -> iter_cnt<=iter_cnt+1. Saturates at MAX_ITER.
  - Early exit: early_term_en && syn_ok -> TERM, decode_success<=1.
  - Limit exit: it_done && iter_cnt+1==MAX_ITER -> TERM. decode_success<=1 if early_term_en && syn_ok in the same cycle, else 0.
  - Priority: if both exits fire in one cycle, success=1 and a single TERM entry occurs. iter_cnt still increments on that cycle.
  - Restart mid-frame: de_frame_start in RUN without an exit -> iter_cnt<=0, stay RUN, no decode_done, statistics unchanged.
- Entering TERM (registered, visible the cycle after the exit condition):
  - termination=1.
  - decode_done=1 for exactly one cycle.
  - frame_cnt+=1.
  - fail_cnt+=1 if decode_success=0.
  - Statistics counters wrap modulo 2**STAT_W.
- TERM:
  - termination is held at 1. iter_cnt is frozen. it_done and syndrome inputs are ignored.
  - de_frame_start=1 -> RUN, iter_cnt<=0, termination<=0 on the next edge.
- termination is a pure registered output and is high only in TERM.
- busy = (state!=IDLE).
- decode_success keeps its value until the next TERM entry.
- Latency: exit condition at edge N -> termination/decode_done high after edge N+1.
- Reset asserted mid-frame: immediate return to IDLE, outputs 0, statistics cleared.

Test Plan:
- Limit exit: de_frame_start, then 10 P2P_V_OUT visits (each 1 cycle, separated by other states), syndrome never valid -> iter_cnt reaches 10; termination and decode_done rise one cycle after the 10th tick; decode_success=0; frame_cnt=1; fail_cnt=1.
- Early exit: early_term_en=1; syn_ok pulsed after the 3rd tick -> TERM with iter_cnt=3, decode_success=1, frame_cnt=1, fail_cnt=0. Repeat with early_term_en=0 -> syndrome ignored, exit at 10.
- Same-cycle exits: syn_ok coincident with the 10th it_done -> a single decode_done pulse, decode_success=1, iter_cnt=10, fail_cnt unchanged.
- Edge detect and handover: hold fsm_state=ST_P2P_V_OUT for 3 cycles -> iter_cnt increments by 1 only. In TERM, assert de_frame_start -> termination=0 and iter_cnt=0 next cycle; the second frame completes with frame_cnt=2.
- Restart/reset: de_frame_start at iter_cnt=5 in RUN -> iter_cnt=0, no decode_done. Then assert rstn=0 in TERM between edges -> termination, busy, iter_cnt, frame_cnt and fail_cnt drop to 0 immediately.
